// File: rtl/aggregate_reducer_if.sv
// Bundle of command, FIFO read-port and result handshake signals for aggregate_reducer.
// The slave modport is the reducer's view; the master modport is the driving side.
interface aggregate_reducer_if #(
  parameter int WIDTH          = 8,
  parameter int ACC_WIDTH      = 24,
  parameter int LOG2_MAX_GROUP = 8
);
  logic                      start;
  logic [1:0]                op;
  logic [LOG2_MAX_GROUP:0]   group_len;
  logic                      busy;
  logic [WIDTH-1:0]          fifo_qout;
  logic                      fifo_empty;
  logic                      fifo_re;
  logic [ACC_WIDTH-1:0]      result;
  logic                      result_valid;
  logic                      result_ready;
  logic                      overflow;

  modport slave (
    input  start, op, group_len, fifo_qout, fifo_empty, result_ready,
    output busy, fifo_re, result, result_valid, overflow
  );

  modport master (
    output start, op, group_len, fifo_qout, fifo_empty, result_ready,
    input  busy, fifo_re, result, result_valid, overflow
  );
endinterface

// File: rtl/aggregate_reducer.sv
// Pops group_len entries from a first-word-fall-through FIFO and reduces them
// (sum, max or min); the aggregate is offered on a valid/ready handshake.
module aggregate_reducer #(
  parameter int WIDTH          = 8,
  parameter int ACC_WIDTH      = 24,
  parameter int LOG2_MAX_GROUP = 8
) (
  input  logic            clk,
  input  logic            rst,
  aggregate_reducer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam logic [1:0] OP_MAX = 2'd1;
  localparam logic [1:0] OP_MIN = 2'd2;
  localparam logic [LOG2_MAX_GROUP:0] ONE = (LOG2_MAX_GROUP+1)'(1);

  state_t                  state_reg;
  logic [1:0]              op_reg;
  logic [LOG2_MAX_GROUP:0] remaining_reg;
  logic [ACC_WIDTH-1:0]    acc_reg;
  logic [ACC_WIDTH-1:0]    result_reg;
  logic                    overflow_reg;
  logic                    busy_reg;
  logic                    valid_reg;

  logic                    pop;
  logic [ACC_WIDTH-1:0]    data_ext;
  logic [ACC_WIDTH:0]      sum_full;
  logic [ACC_WIDTH-1:0]    acc_next;
  logic                    overflow_next;
  logic [ACC_WIDTH-1:0]    identity;

  // Zero-extend the FIFO word to accumulator width bit by bit, so that
  // ACC_WIDTH == WIDTH needs no special case.
  genvar gi;
  generate
    for (gi = 0; gi < ACC_WIDTH; gi++) begin : g_ext
      if (gi < WIDTH) begin : g_bit
        assign data_ext[gi] = bus.fifo_qout[gi];
      end else begin : g_pad
        assign data_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Pop only in ACCUM while data is present and the group is unfinished.
  assign pop = (state_reg == ACCUM) && !bus.fifo_empty && (remaining_reg != '0);

  assign sum_full = {1'b0, acc_reg} + {1'b0, data_ext};
  assign identity = (bus.op == OP_MIN) ? '1 : '0;

  always_comb begin
    acc_next      = sum_full[ACC_WIDTH-1:0];
    overflow_next = overflow_reg | sum_full[ACC_WIDTH];
    case (op_reg)
      OP_MAX: begin
        acc_next      = (data_ext > acc_reg) ? data_ext : acc_reg;
        overflow_next = overflow_reg;
      end
      OP_MIN: begin
        acc_next      = (data_ext < acc_reg) ? data_ext : acc_reg;
        overflow_next = overflow_reg;
      end
      default: begin
        acc_next      = sum_full[ACC_WIDTH-1:0];
        overflow_next = overflow_reg | sum_full[ACC_WIDTH];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      remaining_reg <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_reg        <= bus.op;
            remaining_reg <= bus.group_len;
            acc_reg       <= identity;
            overflow_reg  <= 1'b0;
            busy_reg      <= 1'b1;
            if (bus.group_len != '0) begin
              state_reg <= ACCUM;
            end else begin
              // Empty group reports the identity immediately.
              state_reg  <= OUTPUT;
              result_reg <= identity;
              valid_reg  <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (pop) begin
            acc_reg       <= acc_next;
            overflow_reg  <= overflow_next;
            remaining_reg <= remaining_reg - ONE;
            if (remaining_reg == ONE) begin
              state_reg  <= OUTPUT;
              result_reg <= acc_next;
              valid_reg  <= 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (bus.result_ready) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_re      = pop;
  assign bus.busy         = busy_reg;
  assign bus.result       = result_reg;
  assign bus.result_valid = valid_reg;
  assign bus.overflow     = overflow_reg;

endmodule
